// File: rtl/conv2d_frame_ctrl.sv
// Frame sequencer in front of the 3x3 conv core: admits exactly one DEPTH_P x ROWS_P
// frame per start and tags the core output cycles that carry a complete window.
module conv2d_frame_ctrl #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 16,
    parameter int ROWS_P  = 16,
    parameter int LAT_P   = 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH_P-1:0]         data_i,
    output logic                       core_valid_o,
    input  logic                       core_ready_i,
    output logic [WIDTH_P-1:0]         core_data_o,
    output logic                       win_valid_o,
    output logic [$clog2(ROWS_P)-1:0]  win_row_o,
    output logic [$clog2(DEPTH_P)-1:0] win_col_o,
    output logic                       sof_o,
    output logic                       frame_done_o,
    output logic                       busy_o
);
    localparam int RW = $clog2(ROWS_P);
    localparam int CW = $clog2(DEPTH_P);
    localparam int DW = (LAT_P > 1) ? $clog2(LAT_P) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(DEPTH_P - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS_P - 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(LAT_P - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic [DW-1:0]              drain_q, drain_d;
    logic                       sof_q, sof_d;
    logic                       done_q, done_d;
    logic [LAT_P-1:0]           tag_v_q;
    logic [LAT_P-1:0][RW-1:0]   tag_r_q;
    logic [LAT_P-1:0][CW-1:0]   tag_c_q;

    logic          admit, fire, tag_v_in;
    logic [RW-1:0] tag_r_in;
    logic [CW-1:0] tag_c_in;

    assign admit        = (state_q == PRIME) || (state_q == STREAM);
    assign ready_o      = core_ready_i & admit;
    assign core_valid_o = valid_i & admit;
    assign core_data_o  = data_i;
    assign fire         = valid_i & ready_o;

    // A window completes once the third column of a row at or beyond row 2 arrives.
    assign tag_v_in = fire && (state_q == STREAM) && (col_q >= CW'(2));
    assign tag_r_in = tag_v_in ? row_q - RW'(1) : '0;
    assign tag_c_in = tag_v_in ? col_q - CW'(1) : '0;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        sof_d   = 1'b0;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
            drain_d = '0;
        end else begin
            if (fire) begin
                sof_d = (row_q == '0) && (col_q == '0);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = PRIME;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
                PRIME: begin
                    if (fire && row_q == RW'(1) && col_q == COL_LAST) state_d = STREAM;
                end
                STREAM: begin
                    if (fire && row_q == ROW_LAST && col_q == COL_LAST) begin
                        state_d = DRAIN;
                        col_d   = '0;
                        row_d   = '0;
                        drain_d = '0;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_END) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            sof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            sof_q   <= sof_d;
            done_q  <= done_d;
        end
    end

    // Free-running delay line matching the core's output latency; only abort flushes it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tag_v_q <= '0;
            tag_r_q <= '0;
            tag_c_q <= '0;
        end else if (abort_i) begin
            tag_v_q <= '0;
            tag_r_q <= '0;
            tag_c_q <= '0;
        end else begin
            tag_v_q[0] <= tag_v_in;
            tag_r_q[0] <= tag_r_in;
            tag_c_q[0] <= tag_c_in;
            for (int i = 1; i < LAT_P; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_r_q[i] <= tag_r_q[i-1];
                tag_c_q[i] <= tag_c_q[i-1];
            end
        end
    end

    assign win_valid_o  = tag_v_q[LAT_P-1];
    assign win_row_o    = tag_r_q[LAT_P-1];
    assign win_col_o    = tag_c_q[LAT_P-1];
    assign sof_o        = sof_q;
    assign frame_done_o = done_q;
    assign busy_o       = (state_q != IDLE);
endmodule
